flag_unit: RTL
==============

Name: flag_unit

Overview:
- Producer side of the condition-flag path: computes NZVC from the EX-stage ALU result of flag-setting instructions (ADDS, SUBS, ANDS, CMP, CMN, TST).
- Carries the flags through MEM and WB, then commits them to the architectural flags register.
- Drives a forwarded 4-bit flags bus to the branch controller so that a B.cond can sit directly behind a CMP without a stall.
- Flags bus bit order is {N,Z,V,C} (bits 3..0).

Parameters:
DATASIZE, 64, ALU operand/result width
FLAGSIZE, 4, flag vector width; fixed at 4

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  freeze all state this cycle
ex_valid  in  1  instruction in EX is valid
ex_setflags  in  1  EX instruction updates flags
ex_logic  in  1  EX flag op is logical (AND-class); 0 = add/sub
ex_sub  in  1  EX add/sub is a subtract (b was inverted, carry-in 1)
ex_a_msb  in  1  bit DATASIZE-1 of operand A
ex_b_msb  in  1  bit DATASIZE-1 of operand B before inversion
ex_result  in  DATASIZE  ALU result
ex_carry  in  1  ALU carry-out
flush_ex  in  1  kill EX instruction (branch taken)
wr_en  in  1  direct architectural write (MSR NZCV) at WB
wr_flags  in  FLAGSIZE  value for direct write
flags  out  FLAGSIZE  forwarded flags to branch controller
arch_flags  out  FLAGSIZE  committed flags register
pending  out  1  a flag-setting instruction is in MEM or WB

Behaviour:
- Flag compute (combinational, EX):
  - N = result[DATASIZE-1]; Z = (result == 0).
  - Add/sub: C = ex_carry (subtract carry = NOT borrow). V = (a_msb == beff) & (result_msb != a_msb), where beff = ex_b_msb ^ ex_sub.
  - Logical: C = 0, V = 0.
- State:
  - Stage M: valid_m, flags_m.
  - Stage W: valid_w, flags_w.
  - Register arch.
- Reset (async, rst_n low): valid_m = valid_w = 0; flags_m = flags_w = arch = 4'b0000. All outputs read 0 during reset.
- Rising edge with stall = 0:
  - valid_m <= ex_valid & ex_setflags & ~flush_ex; flags_m <= computed flags when capturing, otherwise held.
  - valid_w <= valid_m; flags_w <= flags_m.
  - arch <= wr_en ? wr_flags : (valid_w ? flags_w : arch).
- Rising edge with stall = 1: all registers hold, including arch. A wr_en asserted during a stall is ignored; the pipeline holds it in WB.
- Forwarding (combinational): flags = valid_m ? flags_m : valid_w ? flags_w : arch. Youngest wins.
- pending = valid_m | valid_w.
- Latency:
  - EX compute is visible on flags one edge later (via M).
  - Commit to arch occurs 2 edges after EX capture.
- Non-setting valid instructions leave flags and arch unchanged. They create a bubble; older M data still advances to W.
- flush_ex kills only the EX capture. Data already in M or W always commits.
- wr_en together with valid_w in the same cycle is illegal by pipeline construction. The bench asserts it never happens; the RTL resolves it with wr_en priority.
- Reset mid-operation drops all in-flight flags with no partial commit.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with ex_* driven -> flags = arch = 0000, pending = 0; release -> still 0000 until the first capture.
- SUBS 5-5 (result 0, carry 1, a_msb 0, b_msb 0, sub 1) -> flags = 0101 (Z,C) one edge later; arch = 0101 after 2 edges.
- ADDS 0x7FFF..F + 1 (result 0x8000..0, carry 0) -> 1010 (N,V). Next cycle ANDS with result 0 -> flags forward 0100 from M while W holds 1010; arch ends at 0100.
- flush_ex on a SUBS producing 1000 -> flags remain at the prior arch value, pending stays 0, arch unchanged.
- stall held 3 cycles with valid_m = 1 -> flags_m, flags_w and arch frozen, flags output constant; release -> commit resumes with the correct order.
- wr_en with wr_flags = 1111 and no valid_w -> arch = 1111 next edge; flags = 1111 when M and W are empty.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit: NZVC producer; computes EX flags, carries them through M/W, commits to arch, forwards youngest.
// Ports: clk, rst_n (async active-low), stall freezes all state; ex_* describe the EX ALU op;
//   flush_ex kills the EX capture; wr_en/wr_flags is a direct architectural write at WB;
//   flags = forwarded {N,Z,V,C}, arch_flags = committed register, pending = setter in M or W.
module flag_unit #(
  parameter int DATASIZE = 64,
  parameter int FLAGSIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                ex_valid,
  input  logic                ex_setflags,
  input  logic                ex_logic,
  input  logic                ex_sub,
  input  logic                ex_a_msb,
  input  logic                ex_b_msb,
  input  logic [DATASIZE-1:0] ex_result,
  input  logic                ex_carry,
  input  logic                flush_ex,
  input  logic                wr_en,
  input  logic [FLAGSIZE-1:0] wr_flags,
  output logic [FLAGSIZE-1:0] flags,
  output logic [FLAGSIZE-1:0] arch_flags,
  output logic                pending
);
  logic                valid_m, valid_w, cap, n, z, v, c;
  logic [FLAGSIZE-1:0] flags_m, flags_w, arch, fx;
  // b_msb is sampled before inversion, so fold the subtract back in to get the effective operand sign
  always_comb begin
    n   = ex_result[DATASIZE-1];
    z   = ~|ex_result;
    v   = ~ex_logic & (ex_a_msb == (ex_b_msb ^ ex_sub)) & (n != ex_a_msb);
    c   = ~ex_logic & ex_carry;
    fx  = {n, z, v, c};
    cap = ex_valid & ex_setflags & ~flush_ex;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_m <= 1'b0;
      valid_w <= 1'b0;
      flags_m <= '0;
      flags_w <= '0;
      arch    <= '0;
    end else if (!stall) begin
      valid_m <= cap;
      if (cap) flags_m <= fx;
      valid_w <= valid_m;
      flags_w <= flags_m;
      arch    <= wr_en ? wr_flags : (valid_w ? flags_w : arch);
    end
  assign flags      = valid_m ? flags_m : (valid_w ? flags_w : arch);
  assign arch_flags = arch;
  assign pending    = valid_m | valid_w;
endmodule
